// File: rtl/i2s_dac_out.sv
// ----------------------------------------------------------------------------
// i2s_dac_out
//   Audio output stage feeding an external stereo DAC. A free-running 8-bit
//   counter produces every DAC clock. The APU level is averaged over the
//   256 clocks of one LR frame with a boxcar filter. The average is
//   optionally converted to two's complement. It is then shifted out
//   left-justified, MSB first, and the same word goes on both channels.
//
// Ports
//   clk_i     system clock
//   rst_i     async active-high reset
//   audio_i   APU mix level, unsigned, sampled every clock
//   mute_i    mute request, sampled at the frame boundary
//   D_SYSCK   DAC system clock (cnt[0])
//   D_BCK     bit clock (cnt[1])
//   D_LRCLK   word select (cnt[7]); 0 = left, 1 = right
//   D_DATA    serial data, registered, changes on BCK falling
//   D_MUTE    DAC mute, registered
//   frame_o   one-cycle pulse when a new word is loaded
//   sample_o  word currently being serialised
// ----------------------------------------------------------------------------
module i2s_dac_out #(
  parameter int SAMPLE_W   = 16,
  parameter int SIGNED_OUT = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SAMPLE_W-1:0] audio_i,
  input  logic                mute_i,
  output logic                D_SYSCK,
  output logic                D_BCK,
  output logic                D_LRCLK,
  output logic                D_DATA,
  output logic                D_MUTE,
  output logic                frame_o,
  output logic [SAMPLE_W-1:0] sample_o
);

  localparam int ACC_W = SAMPLE_W + 8;
  localparam logic [SAMPLE_W-1:0] MSB_MASK = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [7:0]          cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [SAMPLE_W-1:0] word_q, word_d;
  logic                data_q, data_d;
  logic                mute_q, mute_d;
  logic                frame_q, frame_d;

  logic                boundary;
  logic [ACC_W-1:0]    sum;
  logic [SAMPLE_W-1:0] avg;
  logic [SAMPLE_W-1:0] new_word;
  logic [SAMPLE_W-1:0] w_sel;
  logic [4:0]          next_slot;
  logic                next_bit;

  assign boundary = (cnt_q == 8'hFF);
  assign sum      = acc_q + ACC_W'(audio_i);
  // 256 samples summed, so dividing by 256 keeps the top SAMPLE_W bits.
  assign avg      = sum[ACC_W-1:8];
  assign new_word = mute_i ? '0 : ((SIGNED_OUT != 0) ? (avg ^ MSB_MASK) : avg);

  // On the boundary cycle the next slot is slot 0 of the new frame. It must
  // carry the MSB of the word being computed now, not the stored word.
  assign w_sel     = boundary ? new_word : word_q;
  assign cnt_d     = cnt_q + 8'd1;
  assign next_slot = cnt_d[6:2];
  // Slots 0..15 carry bits 15..0 (15 - n == ~n for 4 bits); slots 16..31 are zero.
  assign next_bit  = next_slot[4] ? 1'b0 : w_sel[~next_slot[3:0]];

  always_comb begin
    acc_d   = sum;
    word_d  = word_q;
    mute_d  = mute_q;
    frame_d = 1'b0;
    data_d  = data_q;
    if (boundary) begin
      acc_d   = '0;
      word_d  = new_word;
      mute_d  = mute_i;
      frame_d = 1'b1;
    end
    // Load on the last clock of a BCK period so data moves on BCK falling.
    if (cnt_q[1:0] == 2'b11) data_d = next_bit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      word_q  <= '0;
      data_q  <= 1'b0;
      mute_q  <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      data_q  <= data_d;
      mute_q  <= mute_d;
      frame_q <= frame_d;
    end
  end

  assign D_SYSCK  = cnt_q[0];
  assign D_BCK    = cnt_q[1];
  assign D_LRCLK  = cnt_q[7];
  assign D_DATA   = data_q;
  assign D_MUTE   = mute_q;
  assign frame_o  = frame_q;
  assign sample_o = word_q;

endmodule

// File: tb/tb_i2s_dac_out.sv
module tb_i2s_dac_out;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] audio;
  logic        mute;
  logic        sysck, bck, lrclk, ddata, dmute, frame;
  logic [15:0] sample;

  logic        u_sysck, u_bck, u_lrclk, u_ddata, u_dmute, u_frame;
  logic [15:0] u_sample;
  logic [15:0] u_audio = 16'h1234;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  i2s_dac_out #(.SAMPLE_W(16), .SIGNED_OUT(1)) dut (
    .clk_i(clk), .rst_i(rst), .audio_i(audio), .mute_i(mute),
    .D_SYSCK(sysck), .D_BCK(bck), .D_LRCLK(lrclk), .D_DATA(ddata),
    .D_MUTE(dmute), .frame_o(frame), .sample_o(sample)
  );

  i2s_dac_out #(.SAMPLE_W(16), .SIGNED_OUT(0)) dut_u (
    .clk_i(clk), .rst_i(rst), .audio_i(u_audio), .mute_i(1'b0),
    .D_SYSCK(u_sysck), .D_BCK(u_bck), .D_LRCLK(u_lrclk), .D_DATA(u_ddata),
    .D_MUTE(u_dmute), .frame_o(u_frame), .sample_o(u_sample)
  );

  typedef struct {
    logic [15:0] word;
    logic        mute;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  // k tracks the expected counter value independently of the DUT.
  logic [7:0]  k = 8'd0;
  logic [15:0] cur_w = 16'h0;
  logic        cur_m = 1'b1;
  logic        was_rst = 1'b1;
  int          cyc_err = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (!was_rst) chk("serial_partial_errs", 16'(cyc_err), 16'd0);
      cyc_err = 0;
      k       = 8'd0;
      cur_w   = 16'h0;
      cur_m   = 1'b1;
      was_rst = 1'b1;
    end else begin
      was_rst = 1'b0;
      k = k + 8'd1;
      if (k == 8'd0) begin
        chk("frame_pulse", {15'd0, frame}, 16'd1);
        chk("serial_frame_errs", 16'(cyc_err), 16'd0);
        cyc_err = 0;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got frame_o with sample %h, expected no frame", sample);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sample_o", sample, e.word);
          chk("D_MUTE", {15'd0, dmute}, {15'd0, e.mute});
          cur_w = e.word;
          cur_m = e.mute;
        end
      end else if (frame) begin
        cyc_err++;
      end
      // Slot k[6:2]: bits 15..0 in slots 0..15, zero afterwards.
      if (ddata  !== (k[6] ? 1'b0 : cur_w[4'd15 - k[5:2]])) cyc_err++;
      if (dmute  !== cur_m)  cyc_err++;
      if (sample !== cur_w)  cyc_err++;
      if (sysck  !== k[0])   cyc_err++;
      if (bck    !== k[1])   cyc_err++;
      if (lrclk  !== k[7])   cyc_err++;
    end
  end

  // Unsigned instance: constant 0x1234 averages to itself every frame.
  int u_frames = 0;
  always @(negedge clk) begin
    if (!rst && u_frame) begin
      u_frames++;
      chk("unsigned_sample_o", u_sample, 16'h1234);
    end
  end

  // ---------------- stimulus ----------------
  // Drives 128 clocks of a0/m0 then 128 of a1/m1; the expected word is
  // queued just before the boundary edge. stop_at < 256 aborts the frame.
  task automatic run_frame(input logic [15:0] a0, input logic [15:0] a1,
                           input logic m0, input logic m1,
                           input logic [15:0] ew, input logic em, input int stop_at);
    for (int i = 0; i < 256; i++) begin
      if (i == stop_at) return;
      audio = (i < 128) ? a0 : a1;
      mute  = (i < 128) ? m0 : m1;
      if (i == 255) q.push_back('{ew, em});
      @(negedge clk); #1;
    end
  endtask

  initial begin
    rst   = 1'b1;
    audio = 16'h8000;
    mute  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_D_MUTE", {15'd0, dmute}, 16'd1);
    chk("reset_sample_o", sample, 16'h0);
    rst = 1'b0;

    //        a0        a1        m0    m1    word      mute
    run_frame(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b0, 256);
    run_frame(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b0, 256);
    run_frame(16'h0000, 16'h2000, 1'b0, 1'b0, 16'h9000, 1'b0, 256);
    run_frame(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 256);
    run_frame(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h7FFF, 1'b0, 256);
    run_frame(16'h0100, 16'h0300, 1'b0, 1'b0, 16'h8200, 1'b0, 256);

    // Abort mid right channel (cnt = 0x93), check outputs with no clock edge.
    run_frame(16'h1111, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h93);
    rst = 1'b1;
    #1;
    chk("async_rst_D_DATA",  {15'd0, ddata}, 16'd0);
    chk("async_rst_D_MUTE",  {15'd0, dmute}, 16'd1);
    chk("async_rst_frame_o", {15'd0, frame}, 16'd0);
    chk("async_rst_sample",  sample, 16'h0);
    chk("async_rst_clocks",  {13'd0, lrclk, bck, sysck}, 16'd0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;

    run_frame(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b0, 256);
    run_frame(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 1'b1, 256);
    run_frame(16'h4000, 16'h4000, 1'b0, 1'b0, 16'hC000, 1'b0, 256);

    repeat (8) @(negedge clk);
    #1;
    chk("serial_tail_errs", 16'(cyc_err), 16'd0);
    chk("scoreboard_empty", 16'(q.size()), 16'd0);
    tests++;
    if (u_frames < 8) begin
      fails++;
      $display("FAIL unsigned_frames: got %0d frames, expected at least 8", u_frames);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
